// File: rtl/control_carrera.sv
// control_carrera: race-control FSM for the line-follower timing system.
//
// Conditions the raw finish-line sensor and the arm pushbutton (2-FF sync, debounce,
// rising-edge detect), drives reset_timer/enable_timer of the cronometro, enforces a
// post-start lockout so the robot body cannot re-trigger the line, aborts overlong runs
// and latches the final mm:ss read back from the cronometro.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   sensor_meta   raw line sensor, asynchronous, 1 = robot over line
//   btn_armar     raw pushbutton, asynchronous, 1 = pressed
//   segundos      cronometro seconds (0..59)
//   minutos       cronometro minutes
//   reset_timer   to cronometro: hold count at 0:00
//   enable_timer  to cronometro: count enable
//   tiempo_seg    latched final seconds
//   tiempo_min    latched final minutes
//   tiempo_valido 1 = tiempo_* holds a completed run
//   estado        FSM state code (0 idle, 1 armed, 2 running, 3 finished, 4 timeout)

module control_carrera #(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LOCKOUT_S   = 2,
  parameter int unsigned TIMEOUT_MIN = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_meta,
  input  logic       btn_armar,
  input  logic [5:0] segundos,
  input  logic [3:0] minutos,
  output logic       reset_timer,
  output logic       enable_timer,
  output logic [5:0] tiempo_seg,
  output logic [3:0] tiempo_min,
  output logic       tiempo_valido,
  output logic [2:0] estado
);

  // Debounce window must be at least one cycle.
  localparam int unsigned DbCyc = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DbW   = (DbCyc > 1) ? $clog2(DbCyc + 1) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DbCyc - 1);

  localparam int unsigned LkCyc = LOCKOUT_S * CLK_FREQ;
  localparam int unsigned LkW   = (LkCyc > 1) ? $clog2(LkCyc + 1) : 1;
  localparam logic [LkW-1:0] LkMax = LkW'(LkCyc);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StArmado    = 3'd1;
  localparam logic [2:0] StCorriendo = 3'd2;
  localparam logic [2:0] StFin       = 3'd3;
  localparam logic [2:0] StTimeout   = 3'd4;

  // Conditioning lanes: index 0 = sensor, index 1 = button.
  localparam int unsigned NumIn = 2;
  localparam int unsigned InSen = 0;
  localparam int unsigned InBtn = 1;

  logic [NumIn-1:0] raw_in;
  logic [NumIn-1:0] sync1_q, sync2_q;
  logic [NumIn-1:0] db_q, db_d;
  logic [NumIn-1:0] prev_q;
  logic [NumIn-1:0] pulse;
  logic [DbW-1:0]   db_cnt_q [NumIn];
  logic [DbW-1:0]   db_cnt_d [NumIn];

  assign raw_in = {btn_armar, sensor_meta};

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounced value follows the synced value only after DbCyc consecutive cycles of
  // disagreement; any re-agreement restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < int'(NumIn); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q   <= '0;
      prev_q <= '0;
      for (int i = 0; i < int'(NumIn); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q   <= db_d;
      prev_q <= db_q;
      for (int i = 0; i < int'(NumIn); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // One-cycle pulse on each 0->1 change of the debounced value.
  assign pulse = db_q & ~prev_q;

  logic sen_pulse, btn_pulse;
  assign sen_pulse = pulse[InSen];
  assign btn_pulse = pulse[InBtn];

  // ---------------------------------------------------------------------------
  // Race FSM
  // ---------------------------------------------------------------------------

  logic [2:0]     state_q, state_d;
  logic [LkW-1:0] lk_q, lk_d;
  logic           reset_timer_q, reset_timer_d;
  logic           enable_timer_q, enable_timer_d;
  logic [5:0]     tiempo_seg_q, tiempo_seg_d;
  logic [3:0]     tiempo_min_q, tiempo_min_d;
  logic           tiempo_valido_q, tiempo_valido_d;
  logic           lockout_done;
  logic           timeout_hit;

  assign lockout_done = (lk_q == LkMax);
  assign timeout_hit  = (32'(minutos) >= TIMEOUT_MIN);

  // Priority: button > sensor > timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (btn_pulse) state_d = StArmado;
      end
      StArmado: begin
        if (sen_pulse) state_d = StCorriendo;
      end
      StCorriendo: begin
        if (btn_pulse) begin
          state_d = StArmado;
        end else if (sen_pulse && lockout_done) begin
          state_d = StFin;
        end else if (timeout_hit) begin
          state_d = StTimeout;
        end
      end
      StFin, StTimeout: begin
        if (btn_pulse) state_d = StArmado;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lockout counter restarts on every entry to the running state and saturates.
  always_comb begin
    lk_d = lk_q;
    if (state_d == StCorriendo) begin
      if (state_q != StCorriendo) begin
        lk_d = '0;
      end else if (!lockout_done) begin
        lk_d = lk_q + LkW'(1);
      end
    end
  end

  // Outputs are derived from the next state so they change on the transition edge.
  always_comb begin
    reset_timer_d   = (state_d == StIdle) || (state_d == StArmado);
    enable_timer_d  = (state_d == StCorriendo);
    tiempo_seg_d    = tiempo_seg_q;
    tiempo_min_d    = tiempo_min_q;
    tiempo_valido_d = tiempo_valido_q;
    if (state_d == StArmado) begin
      tiempo_seg_d    = '0;
      tiempo_min_d    = '0;
      tiempo_valido_d = 1'b0;
    end else if ((state_q == StCorriendo) && (state_d == StFin)) begin
      tiempo_seg_d    = segundos;
      tiempo_min_d    = minutos;
      tiempo_valido_d = 1'b1;
    end else if (state_d == StTimeout) begin
      tiempo_valido_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      lk_q            <= '0;
      reset_timer_q   <= 1'b1;
      enable_timer_q  <= 1'b0;
      tiempo_seg_q    <= '0;
      tiempo_min_q    <= '0;
      tiempo_valido_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      lk_q            <= lk_d;
      reset_timer_q   <= reset_timer_d;
      enable_timer_q  <= enable_timer_d;
      tiempo_seg_q    <= tiempo_seg_d;
      tiempo_min_q    <= tiempo_min_d;
      tiempo_valido_q <= tiempo_valido_d;
    end
  end

  assign estado        = state_q;
  assign reset_timer   = reset_timer_q;
  assign enable_timer  = enable_timer_q;
  assign tiempo_seg    = tiempo_seg_q;
  assign tiempo_min    = tiempo_min_q;
  assign tiempo_valido = tiempo_valido_q;

endmodule

// File: tb/tb_control_carrera.sv
// tb_control_carrera: directed self-checking bench for control_carrera.
// Bench parameters give DB_CYC = 2, LK_CYC = 1000, timeout at minutos >= 1, so a raw input
// step reaches the FSM 5 cycles later. Inputs are driven and outputs sampled on the
// falling clock edge.

module tb_control_carrera;

  logic       clk;
  logic       rst_n;
  logic       sensor_meta;
  logic       btn_armar;
  logic [5:0] segundos;
  logic [3:0] minutos;
  logic       reset_timer;
  logic       enable_timer;
  logic [5:0] tiempo_seg;
  logic [3:0] tiempo_min;
  logic       tiempo_valido;
  logic [2:0] estado;

  int n_checks = 0;
  int n_errors = 0;

  control_carrera #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(2),
    .LOCKOUT_S  (1),
    .TIMEOUT_MIN(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_meta  (sensor_meta),
    .btn_armar    (btn_armar),
    .segundos     (segundos),
    .minutos      (minutos),
    .reset_timer  (reset_timer),
    .enable_timer (enable_timer),
    .tiempo_seg   (tiempo_seg),
    .tiempo_min   (tiempo_min),
    .tiempo_valido(tiempo_valido),
    .estado       (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic rt,
                            input logic en, input logic v);
    check({tag, ".estado"}, 32'(estado), 32'(st));
    check({tag, ".reset_timer"}, 32'(reset_timer), 32'(rt));
    check({tag, ".enable_timer"}, 32'(enable_timer), 32'(en));
    check({tag, ".valido"}, 32'(tiempo_valido), 32'(v));
  endtask

  task automatic check_time(input string tag, input logic [3:0] mm, input logic [5:0] ss);
    check({tag, ".min"}, 32'(tiempo_min), 32'(mm));
    check({tag, ".seg"}, 32'(tiempo_seg), 32'(ss));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sensor rise in ARMADO: run starts on the 5th edge, then release after 10 cycles.
  task automatic start_run(input string tag);
    sensor_meta = 1'b1;
    cycles(4);
    check({tag, ".pre"}, 32'(estado), 32'd1);
    cycles(1);
    check_outs(tag, 3'd2, 1'b0, 1'b1, 1'b0);
    cycles(5);
    sensor_meta = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    sensor_meta = 1'b0;
    btn_armar   = 1'b0;
    segundos    = 6'd0;
    minutos     = 4'd0;
    cycles(3);
    check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    check_time("reset", 4'd0, 6'd0);
    rst_n = 1'b1;

    // 1: idle with no stimulus.
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      check_outs("idle_hold", 3'd0, 1'b1, 1'b0, 1'b0);
    end

    // 2: arm exactly 5 cycles after button rise, then start the run.
    btn_armar = 1'b1;
    cycles(4);
    check("arm_lat4", 32'(estado), 32'd0);
    cycles(1);
    check_outs("arm", 3'd1, 1'b1, 1'b0, 1'b0);
    cycles(5);
    btn_armar = 1'b0;
    cycles(10);
    check("arm_hold", 32'(estado), 32'd1);
    start_run("run1");

    // 3: pulse inside the lockout is ignored; one after it finishes the run.
    cycles(485);
    sensor_meta = 1'b1;
    cycles(10);
    sensor_meta = 1'b0;
    cycles(10);
    check_outs("lockout_ignore", 3'd2, 1'b0, 1'b1, 1'b0);
    segundos = 6'd42;
    minutos  = 4'd0;
    cycles(600);
    sensor_meta = 1'b1;
    cycles(5);
    check_outs("fin", 3'd3, 1'b0, 1'b0, 1'b1);
    check_time("fin", 4'd0, 6'd42);
    segundos = 6'd50;
    cycles(5);
    sensor_meta = 1'b0;
    cycles(10);
    check_time("fin_held", 4'd0, 6'd42);
    check("fin_stay", 32'(estado), 32'd3);

    // 4: re-arm clears the time; a 1-cycle sensor glitch is filtered.
    btn_armar = 1'b1;
    cycles(5);
    check_outs("rearm", 3'd1, 1'b1, 1'b0, 1'b0);
    check_time("rearm", 4'd0, 6'd0);
    cycles(5);
    btn_armar = 1'b0;
    cycles(10);
    sensor_meta = 1'b1;
    cycles(1);
    sensor_meta = 1'b0;
    cycles(10);
    check("glitch", 32'(estado), 32'd1);
    start_run("run2");
    segundos = 6'd17;
    cycles(1100);
    sensor_meta = 1'b1;
    cycles(5);
    check_outs("fin2", 3'd3, 1'b0, 1'b0, 1'b1);
    check_time("fin2", 4'd0, 6'd17);
    cycles(5);
    sensor_meta = 1'b0;
    cycles(10);
    // Button and sensor together in FIN: button wins, and the held sensor must not start a run.
    btn_armar   = 1'b1;
    sensor_meta = 1'b1;
    cycles(5);
    check_outs("btn_wins", 3'd1, 1'b1, 1'b0, 1'b0);
    check_time("btn_wins", 4'd0, 6'd0);
    cycles(20);
    check("held_sensor", 32'(estado), 32'd1);
    btn_armar   = 1'b0;
    sensor_meta = 1'b0;
    cycles(10);

    // 5: timeout, then re-arm.
    start_run("run3");
    cycles(20);
    minutos = 4'd1;
    cycles(1);
    check_outs("timeout", 3'd4, 1'b0, 1'b0, 1'b0);
    cycles(10);
    check("timeout_stay", 32'(estado), 32'd4);
    minutos   = 4'd0;
    btn_armar = 1'b1;
    cycles(5);
    check_outs("timeout_rearm", 3'd1, 1'b1, 1'b0, 1'b0);
    cycles(5);
    btn_armar = 1'b0;
    cycles(10);

    // 6: asynchronous reset mid-run.
    start_run("run4");
    segundos = 6'd30;
    minutos  = 4'd0;
    cycles(100);
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 3'd0, 1'b1, 1'b0, 1'b0);
    check_time("async_rst", 4'd0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(10);
    check_outs("post_rst", 3'd0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
